// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through bypass, pending-result scoreboard and reset clear sweep
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rega_addr,
    input  logic [ADDR_W-1:0] regb_addr,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              lock_enable,
    output logic [DATA_W-1:0] rega_data,
    output logic [DATA_W-1:0] regb_data,
    output logic              rega_pending,
    output logic              regb_pending,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                run;
    logic                wr_ok;
    logic                lk_ok;

    assign run   = state == RUN;
    assign busy  = !run;
    assign wr_ok = run && write_enable && !(ZERO_REG != 0 && write_addr == '0);
    assign lk_ok = run && lock_enable && !(ZERO_REG != 0 && lock_addr == '0);

    // Returns {pending, data} for one read port; the bypass also hides the pending bit being retired.
    function automatic logic [DATA_W:0] rd(input logic [ADDR_W-1:0] a);
        logic zero;
        logic hit;
        zero = ZERO_REG != 0 && a == '0;
        hit  = BYPASS != 0 && write_enable && write_addr == a;
        return (!run || zero) ? '0 : hit ? {1'b0, write_data} : {pending[a], regs[a]};
    endfunction

    assign {rega_pending, rega_data} = rd(rega_addr);
    assign {regb_pending, regb_data} = rd(regb_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            pending <= '0;
        end else if (!run) begin
            regs[clr_ptr] <= '0;
            clr_ptr       <= clr_ptr + 1'b1;
            if (clr_ptr == ADDR_W'(DEPTH - 1)) state <= RUN;
        end else begin
            if (wr_ok) begin
                regs[write_addr]    <= write_data;
                pending[write_addr] <= 1'b0;
            end
            // A lock issued alongside a retiring write on the same register must win.
            if (lk_ok) pending[lock_addr] <= 1'b1;
        end
    end
endmodule
